// File: rtl/mano_io_interrupt_if.sv
// Keyboard/printer handshake bundle for the Mano I/O unit.
// slave = the I/O unit, master = the external devices.
interface mano_io_interrupt_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] kbd_data;
    logic              kbd_valid;
    logic              kbd_ready;
    logic [DATA_W-1:0] prt_data;
    logic              prt_valid;
    logic              prt_ack;

    modport master (
        output kbd_data, kbd_valid, prt_ack,
        input  kbd_ready, prt_data, prt_valid
    );

    modport slave (
        input  kbd_data, kbd_valid, prt_ack,
        output kbd_ready, prt_data, prt_valid
    );
endinterface

// File: rtl/mano_io_interrupt.sv
// Mano basic-computer I/O and interrupt unit: INPR/OUTR, FGI/FGO, IEN, R
// and execution of INP, OUT, SKI, SKO, ION, IOF.
module mano_io_interrupt #(
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           t,
    input  logic                 io_exec,
    input  logic [5:0]           ir_io,
    input  logic [DATA_W-1:0]    ac_low,
    mano_io_interrupt_if.slave   dev,
    output logic [DATA_W-1:0]    inpr,
    output logic                 fgi,
    output logic                 fgo,
    output logic                 ien,
    output logic                 r_flag,
    output logic                 skip
);
    logic [DATA_W-1:0] outr;
    logic op_inp, op_out, op_ski, op_sko, op_ion, op_iof;
    logic kbd_take, prt_done, r_set, r_clr;

    // ir_io = {INP, OUT, SKI, SKO, ION, IOF}
    assign op_inp = io_exec & ir_io[5];
    assign op_out = io_exec & ir_io[4];
    assign op_ski = io_exec & ir_io[3];
    assign op_sko = io_exec & ir_io[2];
    assign op_ion = io_exec & ir_io[1];
    assign op_iof = io_exec & ir_io[0];

    assign kbd_take = dev.kbd_valid & ~fgi;
    assign prt_done = dev.prt_ack & ~fgo;
    // RT2 happens at t==2, which the set term excludes, so the two never collide.
    assign r_set    = (t > 3'd2) & ien & (fgi | fgo) & ~r_flag;
    assign r_clr    = (t == 3'd2) & r_flag;

    assign skip          = (op_ski & fgi) | (op_sko & fgo);
    assign dev.kbd_ready = ~fgi;
    assign dev.prt_valid = ~fgo;
    assign dev.prt_data  = outr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inpr   <= '0;
            outr   <= '0;
            fgi    <= 1'b0;
            fgo    <= 1'b1;
            ien    <= 1'b0;
            r_flag <= 1'b0;
        end else begin
            if (kbd_take) begin
                inpr <= dev.kbd_data;
                fgi  <= 1'b1;
            end else if (op_inp) begin
                fgi  <= 1'b0;
            end

            // A fresh OUT beats a printer ack landing on the same edge.
            if (op_out) begin
                outr <= ac_low;
                fgo  <= 1'b0;
            end else if (prt_done) begin
                fgo  <= 1'b1;
            end

            if (op_iof || r_clr)
                ien <= 1'b0;
            else if (op_ion)
                ien <= 1'b1;

            if (r_clr)
                r_flag <= 1'b0;
            else if (r_set)
                r_flag <= 1'b1;
        end
    end
endmodule
